// File: rtl/alu_console.sv
// alu_console: operator console that drives a combinational ALU on the board.
//   - Debounces four active-low push-buttons and turns each press into a 1-cycle pulse.
//   - Assembles WORD_W-bit operands from CHUNK_W-bit switch chunks and holds an aluop.
//   - Captures the ALU result and flags on command (IDLE -> EXEC -> CAPT -> IDLE).
//   - Drives a registered seven-segment display whose source is chosen by sw_view.
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   key_n[3:0]      raw buttons (0 = pressed): 3 clear, 0 load chunk, 1 set op, 2 execute
//   sw_data         chunk value (aluop taken from [3:0])
//   sw_sel          chunk target: s < NCHUNK -> port_a chunk s, else port_b chunk s-NCHUNK
//   sw_view         display source: 0 result, 1 port_a, 2 port_b, 3 aluop
//   port_a/port_b/aluop   operands and opcode driven to the ALU
//   alu_result/alu_flags  ALU outputs ({zero, overflow, negative})
//   hex             active-low segments, digit i at [7*i+:7], bit 0 = segment a
//   flag_led        captured flags; result_valid: capture matches operands; busy: capture running
// Optional build macro: BLANK_LEADING_ZEROS_EN blanks digits above the most
// significant non-zero nibble of the displayed value (digit 0 always lit).
module alu_console #(
  parameter int WORD_W          = 32,
  parameter int CHUNK_W         = 16,
  parameter int DIGITS          = WORD_W / 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  localparam int NCHUNK         = WORD_W / CHUNK_W,
  localparam int SEL_W          = $clog2(2 * NCHUNK)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [3:0]            key_n,
  input  logic [CHUNK_W-1:0]    sw_data,
  input  logic [SEL_W-1:0]      sw_sel,
  input  logic [1:0]            sw_view,
  output logic [WORD_W-1:0]     port_a,
  output logic [WORD_W-1:0]     port_b,
  output logic [3:0]            aluop,
  input  logic [WORD_W-1:0]     alu_result,
  input  logic [2:0]            alu_flags,
  output logic [DIGITS*7-1:0]   hex,
  output logic [2:0]            flag_led,
  output logic                  result_valid,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CAPT = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [3:0]         sync1_r;
  logic [3:0]         sync2_r;
  logic [3:0]         db_r;
  logic [3:0]         press_r;
  logic [CNT_W-1:0]   cnt_r [4];
  logic [WORD_W-1:0]  res_r;
  logic [WORD_W-1:0]  src_s;
  logic [DIGITS*7-1:0] hex_s;

  // Hex digit glyph, active-low segments with bit 0 = segment a.
  function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h27;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      4'hF:    g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // Two-flop synchroniser; stored as pressed = 1 so reset means released.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
    end else begin
      sync1_r <= ~key_n;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing
  // samples; a sample equal to the current level restarts the count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      db_r    <= 4'b0000;
      press_r <= 4'b0000;
      for (int k = 0; k < 4; k++) cnt_r[k] <= {CNT_W{1'b0}};
    end else begin
      for (int k = 0; k < 4; k++) begin
        press_r[k] <= 1'b0;
        if (sync2_r[k] != db_r[k]) begin
          if (cnt_r[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db_r[k]    <= sync2_r[k];
            cnt_r[k]   <= {CNT_W{1'b0}};
            press_r[k] <= sync2_r[k];   // pulse on press edge only
          end else begin
            cnt_r[k] <= cnt_r[k] + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          cnt_r[k] <= {CNT_W{1'b0}};
        end
      end
    end
  end

  // Capture FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Capture FSM next state; execute only wins when no higher-priority pulse is present.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (press_r[2] && !press_r[3] && !press_r[0] && !press_r[1]) state_s = ST_EXEC;
        else                                                      state_s = ST_IDLE;
      end
      ST_EXEC: state_s = ST_CAPT;
      ST_CAPT: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Operand/opcode registers, command decode and result capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      port_a       <= {WORD_W{1'b0}};
      port_b       <= {WORD_W{1'b0}};
      aluop        <= 4'h0;
      res_r        <= {WORD_W{1'b0}};
      flag_led     <= 3'b000;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      busy <= (state_s != ST_IDLE);
      if (state_r == ST_CAPT) begin
        res_r        <= alu_result;
        flag_led     <= alu_flags;
        result_valid <= 1'b1;
      end else if (state_r == ST_IDLE) begin
        if (press_r[3]) begin
          port_a       <= {WORD_W{1'b0}};
          port_b       <= {WORD_W{1'b0}};
          result_valid <= 1'b0;
        end else if (press_r[0]) begin
          for (int c = 0; c < NCHUNK; c++) begin
            if (sw_sel == SEL_W'(c))          port_a[c*CHUNK_W +: CHUNK_W] <= sw_data;
            if (sw_sel == SEL_W'(c + NCHUNK)) port_b[c*CHUNK_W +: CHUNK_W] <= sw_data;
          end
          result_valid <= 1'b0;
        end else if (press_r[1]) begin
          aluop        <= sw_data[3:0];
          result_valid <= 1'b0;
        end else begin
          result_valid <= result_valid;
        end
      end else begin
        result_valid <= result_valid;   // commands are dropped while capturing
      end
    end
  end

  // Display source select.
  always_comb begin
    src_s = res_r;
    case (sw_view)
      2'd0:    src_s = res_r;
      2'd1:    src_s = port_a;
      2'd2:    src_s = port_b;
      2'd3:    src_s = {{(WORD_W-4){1'b0}}, aluop};
      default: src_s = res_r;
    endcase
  end

  // Per-digit glyph generation (optionally blanking leading zeros).
  always_comb begin
    hex_s = {(DIGITS*7){1'b1}};
    for (int i = 0; i < DIGITS; i++) begin
`ifdef BLANK_LEADING_ZEROS_EN
      if ((i != 0) && ((src_s >> (4 * i)) == {WORD_W{1'b0}})) hex_s[7*i +: 7] = 7'b1111111;
      else                                                    hex_s[7*i +: 7] = seg_glyph(src_s[4*i +: 4]);
`else
      hex_s[7*i +: 7] = seg_glyph(src_s[4*i +: 4]);
`endif
    end
  end

  // Registered display output; reset shows '0' on every digit.
  always_ff @(posedge CLK) begin
    if (RST) hex <= {DIGITS{7'b1000000}};
    else     hex <= hex_s;
  end

endmodule

// File: tb/tb_alu_console.sv
// Randomised self-checking bench for alu_console (WORD_W=32, CHUNK_W=16,
// DEBOUNCE_CYCLES=4). A command-level model tracks operands, opcode and
// captured result; a compare process checks every output on each settled cycle.
module tb_alu_console;

  logic        CLK;
  logic        RST;
  logic [3:0]  key_n;
  logic [15:0] sw_data;
  logic [1:0]  sw_sel;
  logic [1:0]  sw_view;
  logic [31:0] port_a, port_b, alu_result;
  logic [3:0]  aluop;
  logic [2:0]  alu_flags, flag_led;
  logic [55:0] hex;
  logic        result_valid, busy;

  int checks = 0;
  int failures = 0;
  bit settled = 1'b0;

  logic [31:0] m_a, m_b, m_res;
  logic [3:0]  m_op;
  logic        m_valid;
  logic [2:0]  m_flags;

  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

  alu_console #(.WORD_W(32), .CHUNK_W(16), .DIGITS(8), .DEBOUNCE_CYCLES(4)) dut (
    .CLK(CLK), .RST(RST), .key_n(key_n), .sw_data(sw_data), .sw_sel(sw_sel),
    .sw_view(sw_view), .port_a(port_a), .port_b(port_b), .aluop(aluop),
    .alu_result(alu_result), .alu_flags(alu_flags), .hex(hex), .flag_led(flag_led),
    .result_valid(result_valid), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Board ALU stand-in: returns {zero, overflow, negative, result}.
  function automatic logic [34:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [31:0] r;
    logic ov;
    ov = 1'b0;
    case (op)
      4'd0: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      4'd1: r = a & b;
      4'd2: r = a | b;
      4'd3: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      4'd4: r = a ^ b;
      default: r = a;
    endcase
    return {(r == 32'd0), ov, r[31], r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_fn(port_a, port_b, aluop);

  function automatic logic [31:0] view_src(input logic [1:0] v);
    if (v == 2'd0) return m_res;
    if (v == 2'd1) return m_a;
    if (v == 2'd2) return m_b;
    return {28'd0, m_op};
  endfunction

  // Expected display, digit by digit from the numeric value.
  function automatic logic [55:0] exp_hex(input logic [31:0] v);
    logic [55:0] e;
    longint unsigned lv;
    lv = longint'(v);
    for (int i = 0; i < 8; i++) begin
      e[7*i +: 7] = GLYPH[(lv / (64'd1 << (4 * i))) % 64'd16];
`ifdef BLANK_LEADING_ZEROS_EN
      if (i > 0 && lv < (64'd1 << (4 * i))) e[7*i +: 7] = 7'h7F;
`endif
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_a = 32'd0; m_b = 32'd0; m_op = 4'd0; m_res = 32'd0; m_valid = 1'b0; m_flags = 3'd0;
  endtask

  // Apply one cycle's worth of accepted pulses with clear > load > op > execute.
  task automatic model_cmd(input logic [3:0] m, output logic ex);
    ex = 1'b0;
    if (m[3]) begin
      m_a = 32'd0; m_b = 32'd0; m_valid = 1'b0;
    end else if (m[0]) begin
      if (sw_sel < 2'd2) m_a[int'(sw_sel) * 16 +: 16] = sw_data;
      else               m_b[(int'(sw_sel) - 2) * 16 +: 16] = sw_data;
      m_valid = 1'b0;
    end else if (m[1]) begin
      m_op = sw_data[3:0]; m_valid = 1'b0;
    end else if (m[2]) begin
      {m_flags, m_res} = alu_fn(m_a, m_b, m_op);
      m_valid = 1'b1; ex = 1'b1;
    end
  endtask

  // Press keys m0, then add keys m1 one cycle later; hold, release, settle.
  task automatic press(input logic [3:0] m0, input logic [3:0] m1);
    int busy_cnt;
    logic ex0, ex1;
    logic [67:0] prev_ops;
    busy_cnt = 0; ex0 = 1'b0; ex1 = 1'b0;
    @(negedge CLK);
    settled = 1'b0;
    prev_ops = {port_a, port_b, aluop};
    key_n = ~m0;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (n == 0) key_n = ~(m0 | m1);
      if (n == 9) key_n = 4'hF;
      if (busy) busy_cnt++;
      if ({port_a, port_b, aluop} != prev_ops) check("valid_drop_on_edit", 64'(result_valid), 64'd0);
      prev_ops = {port_a, port_b, aluop};
    end
    if (m0 != 4'd0) begin
      model_cmd(m0, ex0);
      if (!ex0) model_cmd(m1 & ~m0, ex1);
    end else begin
      model_cmd(m1, ex1);
    end
    check("busy_cycles", 64'(busy_cnt), (ex0 | ex1) ? 64'd2 : 64'd0);
    settled = 1'b1;
  endtask

  task automatic load(input logic [1:0] sel, input logic [15:0] d);
    @(negedge CLK); sw_sel = sel; sw_data = d;
    press(4'b0001, 4'b0000);
  endtask

  task automatic set_view(input logic [1:0] v);
    @(negedge CLK); settled = 1'b0; sw_view = v;
    @(negedge CLK); settled = 1'b1;
  endtask

  // Every settled cycle: all outputs must match the model.
  always @(negedge CLK) begin
    if (settled && !RST) begin
      check("port_a", 64'(port_a), 64'(m_a));
      check("port_b", 64'(port_b), 64'(m_b));
      check("aluop", 64'(aluop), 64'(m_op));
      check("result_valid", 64'(result_valid), 64'(m_valid));
      check("flag_led", 64'(flag_led), 64'(m_flags));
      check("busy_idle", 64'(busy), 64'd0);
      check("hex", 64'(hex), 64'(exp_hex(view_src(sw_view))));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    RST = 1'b1; key_n = 4'hF; sw_data = 16'd0; sw_sel = 2'd0; sw_view = 2'd0;
    model_reset();
    repeat (3) @(negedge CLK);
    check("rst_hex", 64'(hex), 64'({8{7'h40}}));
    check("rst_port_a", 64'(port_a), 64'd0);
    check("rst_port_b", 64'(port_b), 64'd0);
    check("rst_aluop", 64'(aluop), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    RST = 1'b0;
    @(negedge CLK);
    settled = 1'b1;

    // Short glitch must not load.
    @(negedge CLK); settled = 1'b0; sw_sel = 2'd1; sw_data = 16'hDEAD;
    key_n[0] = 1'b0; repeat (3) @(negedge CLK); key_n[0] = 1'b1;
    repeat (10) @(negedge CLK);
    check("glitch_no_load", 64'(port_a), 64'd0);
    // Bounce pattern low 3 / high 1 / low 6 gives a single load.
    key_n[0] = 1'b0; repeat (3) @(negedge CLK);
    key_n[0] = 1'b1; @(negedge CLK);
    key_n[0] = 1'b0; repeat (6) @(negedge CLK);
    key_n[0] = 1'b1; repeat (10) @(negedge CLK);
    check("bounce_load", 64'(port_a), 64'h00000000_DEAD0000);
    m_a = 32'hDEAD0000;
    settled = 1'b1;

    // 5 - 3 = 2 with op 3.
    load(2'd0, 16'h0005); load(2'd1, 16'h0000);
    load(2'd2, 16'h0003); load(2'd3, 16'h0000);
    @(negedge CLK); sw_data = 16'h0003; press(4'b0010, 4'b0000);
    set_view(2'd0);
    press(4'b0100, 4'b0000);
    check("exec_result_digit0", 64'(hex[6:0]), 64'h24);
    check("exec_valid", 64'(result_valid), 64'd1);
    check("exec_flags", 64'(flag_led), 64'd0);
    load(2'd2, 16'h0007);
    check("edit_valid_low", 64'(result_valid), 64'd0);
    check("edit_keeps_display", 64'(hex[6:0]), 64'h24);

    // Clear beats load in the same cycle.
    @(negedge CLK); sw_sel = 2'd0; sw_data = 16'h1234;
    press(4'b1001, 4'b0000);
    check("clear_wins_a", 64'(port_a), 64'd0);
    check("clear_wins_b", 64'(port_b), 64'd0);
    // Load arriving during capture is dropped.
    press(4'b0100, 4'b0001);
    check("load_while_busy", 64'(port_a), 64'd0);

    // Leading-zero display of port_a = 0x00000A10.
    load(2'd0, 16'h0A10);
    set_view(2'd1);
    check("lz_low_digits", 64'(hex[20:0]), 64'({7'h08, 7'h79, 7'h40}));
`ifdef BLANK_LEADING_ZEROS_EN
    check("lz_high_digits", 64'(hex[55:21]), 64'({5{7'h7F}}));
`else
    check("lz_high_digits", 64'(hex[55:21]), 64'({5{7'h40}}));
`endif

    // Reset in the middle of a capture aborts it.
    load(2'd1, 16'h8001);
    @(negedge CLK); settled = 1'b0; key_n[2] = 1'b0;
    for (int n = 0; n < 20 && !busy; n++) @(negedge CLK);
    check("busy_seen", 64'(busy), 64'd1);
    RST = 1'b1; key_n = 4'hF;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    model_reset();
    check("abort_valid", 64'(result_valid), 64'd0);
    check("abort_flags", 64'(flag_led), 64'd0);
    @(negedge CLK); settled = 1'b1;

    // Randomised command mix.
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: load(2'($urandom_range(0, 3)), 16'($urandom));
        3: begin
          @(negedge CLK); sw_data = {12'($urandom), 4'($urandom_range(0, 5))};
          press(4'b0010, 4'b0000);
        end
        4, 5: press(4'b0100, 4'b0000);
        6: set_view(2'($urandom_range(0, 3)));
        7: begin
          @(negedge CLK); sw_sel = 2'($urandom_range(0, 3)); sw_data = 16'($urandom);
          press(4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)));
        end
        8: begin
          @(negedge CLK); settled = 1'b0;
          key_n[$urandom_range(0, 3)] = 1'b0;
          repeat ($urandom_range(1, 3)) @(negedge CLK);
          key_n = 4'hF;
          repeat (8) @(negedge CLK);
          settled = 1'b1;
        end
        default: press(4'b1000, 4'b0000);
      endcase
    end

    @(negedge CLK);
    settled = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
